// File: rtl/audio_i2s_tx_if.sv
// Sample-pair input channel of the I2S transmitter.
// A pair moves on every clk edge where in_valid && in_ready; the source holds
// in_l/in_r steady while in_valid is high and in_ready is low.
interface audio_i2s_tx_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_l;
  logic [DW-1:0] in_r;

  modport master (output in_valid, output in_l, output in_r, input in_ready);
  modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified DAC serializer: pair FIFO, clock dividers,
// saturating cross-mix, channel swap and underrun reporting.
module audio_i2s_tx #(
  parameter int DW    = 16,
  parameter int SLOT  = 16,
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  audio_i2s_tx_if.slave src,
  input  logic          mix,
  input  logic          exchan,
  input  logic          i2s_mode,
  output logic          underrun,
  output logic          aud_xck,
  output logic          aud_bclk,
  output logic          aud_daclrck,
  output logic          aud_dacdat,
  output logic          debug_state
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(2 * SLOT);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(2 * SLOT - 1);
  localparam logic [BCW-1:0] SLOT_B   = BCW'(SLOT);
  localparam logic [BCW-1:0] DW_B     = BCW'(DW);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt, bit_d;
  logic           tick, fall, load;

  logic [DW-1:0]  fifo_l [DEPTH];
  logic [DW-1:0]  fifo_r [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           empty, full, push, pop;

  logic [DW-1:0]  held_l, held_r;
  logic           mix_q, exchan_q, i2s_q;
  logic [DW-1:0]  sel_l, sel_r, mixed_l, mixed_r, word_left, word_right;
  logic           sel_mix, sel_exchan, sel_i2s;
  logic [DW-1:0]  slot_word, shifted;
  logic [BCW-1:0] slot_bit;
  logic           right_slot, lj_bit, lj_prev;

  // Saturating a + (b >>> 1) evaluated in DW+1 bits.
  function automatic logic [DW-1:0] sat_mix(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b[DW-1], b[DW-1:1]};
    return (sum[DW] != sum[DW-1]) ? {sum[DW], {(DW-1){~sum[DW]}}} : sum[DW-1:0];
  endfunction

  assign tick        = (div_cnt == DIV_LAST);
  assign fall        = tick && aud_bclk;
  assign debug_state = state_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
      aud_xck  <= 1'b0;
    end else begin
      aud_xck <= ~aud_xck;
      if (tick) begin
        div_cnt  <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        div_cnt <= div_cnt + DCW'(1);
      end
    end
  end

  // The very first falling edge starts the frame; afterwards a load happens on wrap.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_WAIT;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_cnt;
    load    = 1'b0;
    if (fall) begin
      case (state_q)
        ST_WAIT: begin
          state_d = ST_RUN;
          bit_d   = '0;
          load    = 1'b1;
        end
        ST_RUN: begin
          if (bit_cnt == BIT_LAST) begin
            bit_d = '0;
            load  = 1'b1;
          end else begin
            bit_d = bit_cnt + BCW'(1);
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // in_ready comes from the registered count, so a same-cycle pop never frees a full FIFO.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign src.in_ready = !full;
  assign push         = src.in_valid && !full;
  assign pop          = load && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_l[wr_ptr] <= src.in_l;
      fifo_r[wr_ptr] <= src.in_r;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // On a popping load the fresh pair and modes take effect in the same edge.
  always_comb begin
    sel_l      = pop ? fifo_l[rd_ptr] : held_l;
    sel_r      = pop ? fifo_r[rd_ptr] : held_r;
    sel_mix    = pop ? mix            : mix_q;
    sel_exchan = pop ? exchan         : exchan_q;
    sel_i2s    = pop ? i2s_mode       : i2s_q;
    mixed_l    = sel_mix ? sat_mix(sel_l, sel_r) : sel_l;
    mixed_r    = sel_mix ? sat_mix(sel_r, sel_l) : sel_r;
    word_left  = sel_exchan ? mixed_r : mixed_l;
    word_right = sel_exchan ? mixed_l : mixed_r;
  end

  always_comb begin
    right_slot = (bit_d >= SLOT_B);
    slot_bit   = right_slot ? (bit_d - SLOT_B) : bit_d;
    slot_word  = right_slot ? word_right : word_left;
    shifted    = slot_word << slot_bit;
    lj_bit     = (slot_bit < DW_B) && shifted[DW-1];
  end

  // lj_prev is the left-justified stream one BCLK late, which is exactly the I2S stream.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      held_l      <= '0;
      held_r      <= '0;
      mix_q       <= 1'b0;
      exchan_q    <= 1'b0;
      i2s_q       <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      lj_prev     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= load && empty;
      if (pop) begin
        held_l   <= fifo_l[rd_ptr];
        held_r   <= fifo_r[rd_ptr];
        mix_q    <= mix;
        exchan_q <= exchan;
        i2s_q    <= i2s_mode;
      end
      if (fall) begin
        aud_daclrck <= right_slot;
        aud_dacdat  <= sel_i2s ? lj_prev : lj_bit;
        lj_prev     <= lj_bit;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomized scoreboard bench for audio_i2s_tx against a queue-based frame model.
module tb_audio_i2s_tx;
  localparam int DW    = 16;
  localparam int SLOT  = 16;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * SLOT * DIV;
  localparam int FW    = 2 * DW + 1;
  localparam int MAXV  = (1 << (DW - 1)) - 1;
  localparam int MINV  = -(1 << (DW - 1));

  logic clk, nreset;
  logic mix, exchan, i2s_mode;
  logic underrun, aud_xck, aud_bclk, aud_daclrck, aud_dacdat, debug_state;

  audio_i2s_tx_if #(.DW(DW)) src_if ();

  audio_i2s_tx #(.DW(DW), .SLOT(SLOT), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset), .src(src_if),
    .mix(mix), .exchan(exchan), .i2s_mode(i2s_mode),
    .underrun(underrun), .aud_xck(aud_xck), .aud_bclk(aud_bclk),
    .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat), .debug_state(debug_state)
  );

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_q[$];   // {i2s, left word, right word} per frame load
  logic exp_xck = 1'b0, exp_bclk = 1'b0, exp_ready = 1'b1, exp_und = 1'b0;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mix_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int s;
    s = int'($signed(x)) + (int'($signed(y)) >>> 1);
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return DW'(s);
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                               input logic m, input logic e, input logic i);
    logic [DW-1:0] a, b;
    a = m ? mix_ref(l, r) : l;
    b = m ? mix_ref(r, l) : r;
    return e ? {i, b, a} : {i, a, b};
  endfunction

  function automatic logic lj_ref(input logic [FW-1:0] f, input int b);
    logic [DW-1:0] w;
    int s;
    w = (b < SLOT) ? f[2*DW-1:DW] : f[DW-1:0];
    s = b % SLOT;
    return (s < DW) ? w[DW-1-s] : 1'b0;
  endfunction

  // reference model: frame loads fall on a fixed arithmetic schedule after reset release
  initial begin : model
    int cyc, pre;
    bit load, accept;
    logic [DW-1:0] pl, pr;
    logic pm, pe, pi;
    logic [2*DW-1:0] mq[$];
    cyc = 0; pl = '0; pr = '0; pm = 0; pe = 0; pi = 0;
    forever begin
      @(posedge clk);
      if (!nreset) begin
        cyc = 0; mq.delete(); exp_q.delete();
        pl = '0; pr = '0; pm = 0; pe = 0; pi = 0;
        exp_xck = 0; exp_bclk = 0; exp_ready = 1; exp_und = 0;
      end else begin
        cyc++;
        load = (cyc >= 2 * DIV) && (((cyc - 2 * DIV) % FRAME) == 0);
        pre = mq.size();
        accept = src_if.in_valid && (pre < DEPTH);
        exp_und = load && (pre == 0);
        if (load && pre > 0) begin
          {pl, pr} = mq.pop_front();
          pm = mix; pe = exchan; pi = i2s_mode;
        end
        if (load) exp_q.push_back(make_frame(pl, pr, pm, pe, pi));
        if (accept) mq.push_back({src_if.in_l, src_if.in_r});
        exp_ready = (mq.size() < DEPTH);
        exp_xck = (cyc % 2) == 1;
        exp_bclk = ((cyc / DIV) % 2) == 1;
      end
    end
  end

  // per-cycle pin monitor
  initial begin : pin_mon
    forever begin
      @(negedge clk);
      if (nreset)
        chk("pins_xck_bclk_ready_underrun", {aud_xck, aud_bclk, src_if.in_ready, underrun},
            {exp_xck, exp_bclk, exp_ready, exp_und});
    end
  end

  // serial monitor: captures one bit per BCLK rising edge and checks whole frames
  initial begin : ser_mon
    logic bclk_prev, dat_prev, skip, have, prev_lj, lj, eb, stable_ok;
    int b;
    logic [FW-1:0] cur;
    logic [2*SLOT-1:0] act_dat, exp_dat, act_lr, exp_lr;
    bclk_prev = 0; dat_prev = 0; skip = 1; have = 0; prev_lj = 0; stable_ok = 1; b = 0;
    cur = '0; act_dat = '0; exp_dat = '0; act_lr = '0; exp_lr = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        bclk_prev = 0; dat_prev = 0; skip = 1; have = 0; prev_lj = 0; stable_ok = 1; b = 0;
      end else begin
        if (aud_bclk && !bclk_prev) begin
          if (skip) begin
            skip = 0;
          end else begin
            if (b == 0) begin
              chk("frame_expected", exp_q.size() != 0, 1'b1);
              have = (exp_q.size() != 0);
              if (have) cur = exp_q.pop_front();
              stable_ok = 1;
            end
            lj = lj_ref(cur, b);
            eb = cur[FW-1] ? prev_lj : lj;
            prev_lj = lj;
            act_dat[2*SLOT-1-b] = aud_dacdat;
            exp_dat[2*SLOT-1-b] = eb;
            act_lr[2*SLOT-1-b] = aud_daclrck;
            exp_lr[2*SLOT-1-b] = (b >= SLOT);
            if (aud_dacdat !== dat_prev) stable_ok = 0;
            if (b == 2 * SLOT - 1 && have) begin
              chk("frame_dacdat", act_dat, exp_dat);
              chk("frame_lrck", act_lr, exp_lr);
              chk("dacdat_stable_at_bclk_rise", stable_ok, 1'b1);
            end
            b = (b + 1) % (2 * SLOT);
          end
        end
        bclk_prev = aud_bclk;
        dat_prev = aud_dacdat;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int waited;
    @(negedge clk);
    src_if.in_valid = 1'b1;
    src_if.in_l = l;
    src_if.in_r = r;
    waited = 0;
    while (src_if.in_ready !== 1'b1 && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 4 * FRAME) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    src_if.in_valid = 1'b0;
  endtask

  task automatic set_mode(input logic m, input logic e, input logic i);
    mix = m; exchan = e; i2s_mode = i;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic wait_lrck(input logic level);
    int w;
    w = 0;
    while (aud_daclrck !== level && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    chk("lrck_wait_in_budget", w < 2 * FRAME, 1'b1);
  endtask

  // stimulus
  initial begin : stim
    nreset = 1'b0;
    src_if.in_valid = 1'b0;
    src_if.in_l = '0;
    src_if.in_r = '0;
    set_mode(0, 0, 0);
    #2;
    chk("reset_pins", {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, underrun, src_if.in_ready},
        6'b000001);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // idle: underrun every frame, silent data
    repeat (600) @(negedge clk);

    set_mode(0, 0, 0);
    send(DW'(16'h8001), DW'(16'h7FFE)); idle(); wait_frames(2);

    set_mode(0, 0, 1);
    send(DW'(16'h8001), DW'(16'h7FFE)); idle(); wait_frames(3);

    set_mode(1, 0, 0);
    send(DW'(16'h7000), DW'(16'h7000));
    send(DW'(16'h8000), DW'(16'h8000)); idle(); wait_frames(3);

    set_mode(0, 1, 0);
    send(DW'(16'h1234), DW'(16'h0000)); idle(); wait_frames(2);

    // six back-to-back pairs against a four-deep FIFO
    set_mode(0, 0, 0);
    for (int i = 0; i < 6; i++) send(DW'(16'h1111 * (i + 1)), DW'(16'hF0F0 - 16'h0101 * i));
    idle(); wait_frames(6);

    // random batches, modes reshuffled between pushes
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(4, 8);
      for (int j = 0; j < n; j++) begin
        send(DW'($urandom), DW'($urandom));
        @(negedge clk);
        src_if.in_valid = 1'b0;
        set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
      wait_frames(DEPTH + 2);
    end

    // reset in the middle of a right slot with two pairs queued
    set_mode(0, 0, 1);
    wait_lrck(1'b0);
    wait_lrck(1'b1);
    send(DW'(16'hABCD), DW'(16'h1357));
    send(DW'(16'h2468), DW'(16'hFEDC));
    idle();
    repeat (10) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("midframe_reset_pins", {aud_xck, aud_bclk, aud_daclrck, aud_dacdat, underrun, src_if.in_ready},
        6'b000001);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    wait_frames(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Parametrised stereo audio serializer that drives an external I2S/left-justified DAC from the system clock. It buffers stereo samples in a small FIFO with a valid/ready input handshake and generates MCLK (xck), BCLK and LRCK by division. Sample width, slot width and clock ratio are configurable, and it serializes MSB-first. It provides a saturating L/R cross-mix, channel swap, I2S or left-justified framing, and underrun reporting. It sits between the sound mixer and the board audio codec pins.

## Interface
- DW, 16: sample width in bits (8..24).
- SLOT, 16: BCLK periods per channel slot; SLOT >= DW.
- DIV, 4: clk cycles per BCLK half-period (>= 2). BCLK = clk/(2*DIV).
- DEPTH, 4: FIFO depth in stereo pairs; power of 2, >= 2.
- clk  in  1  system clock (32 MHz nominal).
- nreset  in  1  Reset nreset, asynchronous, active-low; clock clk.
- in_valid  in  1  in_l/in_r hold a valid sample pair.
- in_ready  out  1  FIFO can accept a pair this cycle.
- in_l, in_r  in  DW  signed two's-complement samples.
- mix  in  1  enable saturating cross-mix; sampled at frame load.
- exchan  in  1  swap channels; sampled at frame load.
- i2s_mode  in  1  1 = I2S (1-bit delay), 0 = left-justified; sampled at frame load.
- underrun  out  1  1-cycle pulse when a frame load finds the FIFO empty.
- aud_xck  out  1  clk/2.
- aud_bclk  out  1  bit clock.
- aud_daclrck  out  1  0 = left slot, 1 = right slot.
- aud_dacdat  out  1  serial data.

## Operation
- Reset values: aud_xck, aud_bclk, aud_daclrck, aud_dacdat, and underrun are 0. in_ready is 1. The FIFO is empty. The held pair is 0/0.
- Divider: counter 0..DIV-1. aud_bclk toggles when the counter is DIV-1.
- A BCLK falling edge is the clk edge where aud_bclk goes 1->0. aud_daclrck and aud_dacdat change only on BCLK falling edges, plus the first falling edge after reset.
- Bit counter 0..2*SLOT-1 advances on each falling edge and wraps.
- aud_daclrck = 0 for bits 0..SLOT-1 and 1 for bits SLOT..2*SLOT-1.
- Frame load occurs on the falling edge where the bit counter wraps to 0:
  - If the FIFO is not empty: pop one pair and latch mix/exchan/i2s_mode.
  - If the FIFO is empty: reuse the held pair and pulse underrun for one clk.
- Mix, with DW+1-bit intermediate:
  - L' = sat(L + (R>>>1)), R' = sat(R + (L>>>1)).
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - mix=0 passes samples through unchanged.
- Swap: exchan=1 sends R' in the left slot and L' in the right slot.
- Left-justified mode: the slot sample MSB is on slot bit 0, the LSB on slot bit DW-1, and slot bits DW..SLOT-1 are 0.
- I2S mode: all data is delayed by one BCLK. Slot bit 0 carries the previous slot's bit SLOT-1. For the left slot with SLOT==DW, that is the previous frame's right LSB.
- FIFO behaviour:
  - Push when in_valid && in_ready.
  - in_ready = !full, reflecting the count before this cycle's pop. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Mode inputs changing mid-frame have no effect until the next frame load.
- Reset asserted mid-frame immediately returns all state to reset values. The FIFO contents are discarded.

## Timing
- aud_xck toggles every clk.
- BCLK period = 2*DIV clk. Frame = 4*SLOT*DIV clk (defaults: 8 and 256 clk, i.e. 125 kHz frame at 32 MHz).
- The first BCLK rising edge occurs DIV clk edges after nreset deasserts.
- Bit counter starts at 0 on the first falling edge; the first frame load happens there.
- Latency: a pair accepted at cycle t is output starting at the first frame load after t.
  - With an empty FIFO, it goes out on the next frame load: at most 1 frame plus 1 clk.
  - Otherwise it waits behind queued pairs: (queued pairs + 1) frames max.
- in_ready updates the cycle after a pop or push.
- underrun is high for exactly the frame-load clk.

## Test plan
- Reset and defaults, no input: check that underrun pulses every 256 clk and dacdat stays 0. Check that aud_bclk has period 8, aud_daclrck period 256, and aud_xck period 2.
- LJ mode, push L=0x8001, R=0x7FFE: left slot bits read 1000000000000001 with lrck=0, right slot reads 0111111111111110 with lrck=1, and dacdat is stable across each BCLK rising edge.
- I2S mode, same pair, SLOT=16:
  - Left-slot bit 0 equals the previous right LSB (0).
  - Left MSB 1 appears on bit 1.
  - Right LSB 0 appears on bit 0 of the next frame.
- mix=1, L=0x7000, R=0x7000: both slots output 0x7FFF (saturated). L=0x8000, R=0x8000 -> 0x8000. With exchan=1 and L=0x1234, R=0x0000 (mix=0), the left slot outputs 0x0000.
- FIFO: hold in_valid with 6 distinct pairs while the FIFO drains at frame rate.
  - in_ready drops after 4 accepted pairs.
  - No pair is lost or duplicated, and output order matches input.
  - A push attempted at full in the same cycle as a pop is refused.
- Reset asserted mid-right-slot with 2 pairs queued: all outputs return to 0 asynchronously and in_ready=1. After release, the first frame outputs 0/0 and underrun pulses.
